// File: rtl/lzc_norm_arb.sv
// Shared 64-bit leading-zero normalizer: two requesters take turns on one
// 32-bit leading-one detector, scanning the upper half first, then the lower.

module lzc_32 (
   input  logic [31:0] x,
   output logic        v,
   output logic [4:0]  c
);

   // Ascending scan; the last hit wins, so c ends on the most-significant set bit.
   always_comb begin
      c = 5'd0;
      for (int i = 0; i < 32; i++) begin
         if (x[i]) c = i[4:0];
      end
   end

   assign v = |x;

endmodule

// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for an operand; grant drives one ready
// SCAN_HI  | counter sees data[63:32]; a hit settles the count
// SCAN_LO  | counter sees data[31:0]; settles count and the zero flag
// SHIFT    | left-shift the mantissa by the count
// DONE     | result presented until the consumer takes it
module lzc_norm_arb (
   input  logic        clock,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [63:0] req0_data,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [63:0] req1_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [6:0]  rsp_count,
   output logic [63:0] rsp_data,
   output logic        rsp_zero
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SCAN_HI = 3'd1;
   localparam logic [2:0] ST_SCAN_LO = 3'd2;
   localparam logic [2:0] ST_SHIFT   = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   logic [2:0]  state;
   logic        ptr;
   logic [63:0] data_q;
   logic        id_q;
   logic [6:0]  cnt_q;
   logic        zero_q;

   logic        gnt;
   logic        accept;
   logic [31:0] lz_in;
   logic        lz_v;
   logic [4:0]  lz_c;

   // Round-robin pointer only breaks ties; a lone requester is served at once.
   assign gnt    = (req0_valid & req1_valid) ? ptr : req1_valid;
   assign accept = (state == ST_IDLE) & (gnt ? req1_valid : req0_valid);

   assign req0_ready = (state == ST_IDLE) & ~gnt;
   assign req1_ready = (state == ST_IDLE) &  gnt;

   assign lz_in = (state == ST_SCAN_LO) ? data_q[31:0] : data_q[63:32];

   lzc_32 u_lzc (
      .x (lz_in),
      .v (lz_v),
      .c (lz_c)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         ptr    <= 1'b0;
         data_q <= 64'd0;
         id_q   <= 1'b0;
         cnt_q  <= 7'd0;
         zero_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  data_q <= gnt ? req1_data : req0_data;
                  id_q   <= gnt;
                  ptr    <= ~gnt;
                  state  <= ST_SCAN_HI;
               end
            end
            ST_SCAN_HI: begin
               if (lz_v) begin
                  cnt_q  <= 7'd31 - {2'b00, lz_c};
                  zero_q <= 1'b0;
                  state  <= ST_SHIFT;
               end else begin
                  state  <= ST_SCAN_LO;
               end
            end
            ST_SCAN_LO: begin
               // 32 + (31 - c) folded into one subtraction
               if (lz_v) begin
                  cnt_q  <= 7'd63 - {2'b00, lz_c};
                  zero_q <= 1'b0;
               end else begin
                  cnt_q  <= 7'd64;
                  zero_q <= 1'b1;
               end
               state <= ST_SHIFT;
            end
            ST_SHIFT: begin
               data_q <= data_q << cnt_q;
               state  <= ST_DONE;
            end
            ST_DONE: begin
               if (rsp_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign rsp_valid = (state == ST_DONE);
   assign rsp_id    = id_q;
   assign rsp_count = cnt_q;
   assign rsp_data  = data_q;
   assign rsp_zero  = zero_q;

endmodule

// File: tb/tb_lzc_norm_arb.sv
// Bench for lzc_norm_arb: directed operands with literal expectations plus a
// per-cycle comparison against a transaction-level model of arbitration and latency.

module tb_lzc_norm_arb;

   logic        clock;
   logic        reset;
   logic        req0_valid, req0_ready;
   logic [63:0] req0_data;
   logic        req1_valid, req1_ready;
   logic [63:0] req1_data;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
   logic [6:0]  rsp_count;
   logic [63:0] rsp_data;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   lzc_norm_arb dut (
      .clock      (clock),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_data  (req0_data),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_data  (req1_data),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_count  (rsp_count),
      .rsp_data   (rsp_data),
      .rsp_zero   (rsp_zero)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic timeout(input string nm);
      n_checks++;
      n_err++;
      $display("FAIL %s: got timeout expected event", nm);
   endtask

   function automatic int lz(input logic [63:0] x);
      for (int i = 63; i >= 0; i--) begin
         if (x[i]) return 63 - i;
      end
      return 64;
   endfunction

   // model: one operand in flight, counted down to its response cycle
   bit          m_busy, m_valid, m_ptr, m_id, m_zero;
   int          m_left, m_count;
   logic [63:0] m_data;

   always @(negedge clock) begin
      bit          idle, g;
      logic [63:0] x;
      if (reset) begin
         m_busy = 0; m_valid = 0; m_ptr = 0; m_left = 0;
         chk("rst_valid", rsp_valid, 0);
         chk("rst_id", rsp_id, 0);
         chk("rst_count", rsp_count, 0);
         chk("rst_data", rsp_data, 0);
         chk("rst_zero", rsp_zero, 0);
      end else begin
         idle = !m_busy;
         g = (req0_valid && req1_valid) ? m_ptr : req1_valid;
         chk("m_ready0", req0_ready, idle && !g);
         chk("m_ready1", req1_ready, idle && g);
         chk("m_rsp_valid", rsp_valid, m_valid);
         if (m_valid) begin
            chk("m_id", rsp_id, m_id);
            chk("m_count", rsp_count, m_count);
            chk("m_data", rsp_data, m_data);
            chk("m_zero", rsp_zero, m_zero);
         end
         if (idle) begin
            if (g ? req1_valid : req0_valid) begin
               x = g ? req1_data : req0_data;
               m_id = g; m_count = lz(x); m_zero = (x == 0);
               m_data = x << m_count;
               m_left = (x[63:32] != 0) ? 2 : 3;
               m_busy = 1; m_ptr = !g;
            end
         end else if (m_valid) begin
            if (rsp_ready) begin m_valid = 0; m_busy = 0; end
         end else begin
            m_left--;
            if (m_left == 0) m_valid = 1;
         end
      end
   end

   task automatic accept(input int sel, input logic [63:0] d, output int tacc);
      @(posedge clock); #1;
      if (sel == 0) begin req0_valid = 1; req0_data = d; end
      else          begin req1_valid = 1; req1_data = d; end
      tacc = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (sel == 0 ? req0_ready : req1_ready) begin tacc = cyc; break; end
      end
      if (tacc < 0) timeout("accept");
      @(posedge clock); #1;
      if (sel == 0) req0_valid = 0; else req1_valid = 0;
   endtask

   task automatic wait_rsp(output int tv);
      tv = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (rsp_valid) begin tv = cyc; break; end
      end
      if (tv < 0) timeout("rsp_valid");
   endtask

   task automatic directed(input string nm, input int sel, input logic [63:0] d,
                           input int lat, input int cnt, input logic [63:0] nd, input bit z);
      int ta, tv;
      accept(sel, d, ta);
      wait_rsp(tv);
      chk({nm, "_lat"}, tv - ta, lat);
      chk({nm, "_id"}, rsp_id, sel);
      chk({nm, "_count"}, rsp_count, cnt);
      chk({nm, "_data"}, rsp_data, nd);
      chk({nm, "_zero"}, rsp_zero, z);
   endtask

   initial begin
      int ta, tv, th;
      int grants[$];
      bit h0, h1;
      logic [63:0] a_seq [4];
      logic [63:0] b_seq [4];
      a_seq = '{64'h0000_0000_0000_00F0, 64'h0000_0003_0000_0000, 64'h1, 64'h2};
      b_seq = '{64'h0F00_0000_0000_0000, 64'h0000_0000_0000_0005, 64'h3, 64'h4};

      reset = 1; req0_valid = 0; req1_valid = 0;
      req0_data = 0; req1_data = 0; rsp_ready = 1;
      repeat (3) @(posedge clock);
      #1 reset = 0;

      chk("pin_lz_31", lz(64'h0000_0001_0000_0000), 31);
      chk("pin_lz_64", lz(64'h0), 64);
      chk("pin_lz_8", lz(64'h00F0_0000_0000_0000), 8);

      directed("hi_one",  0, 64'h0000_0001_0000_0000, 3, 31, 64'h8000_0000_0000_0000, 0);
      directed("lo_one",  1, 64'h0000_0000_0000_0001, 4, 63, 64'h8000_0000_0000_0000, 0);
      directed("zero",    0, 64'h0,                   4, 64, 64'h0, 1);
      directed("msb_set", 0, 64'h8000_0000_0000_0001, 3, 0,  64'h8000_0000_0000_0001, 0);
      directed("lo_msb",  1, 64'h0000_0000_8000_0000, 4, 32, 64'h8000_0000_0000_0000, 0);

      // Both requesters valid continuously from reset
      @(posedge clock); #1 reset = 1;
      @(posedge clock); #1 reset = 0;
      req0_valid = 1; req0_data = a_seq[0];
      req1_valid = 1; req1_data = b_seq[0];
      for (int k = 0; k < 80 && grants.size() < 4; k++) begin
         @(negedge clock);
         chk("both_ready", req0_ready & req1_ready, 0);
         h0 = req0_ready & req0_valid;
         h1 = req1_ready & req1_valid;
         @(posedge clock); #1;
         if (h0) begin grants.push_back(0); req0_data = a_seq[grants.size() % 4]; end
         if (h1) begin grants.push_back(1); req1_data = b_seq[grants.size() % 4]; end
      end
      req0_valid = 0; req1_valid = 0;
      if (grants.size() < 4) timeout("grant_seq");
      else for (int i = 0; i < 4; i++) chk($sformatf("grant_%0d", i), grants[i], i % 2);
      repeat (8) @(posedge clock);

      // Backpressure in DONE
      #1 rsp_ready = 0;
      accept(0, 64'h00F0_0000_0000_0000, ta);
      req1_valid = 1; req1_data = 64'h5;
      wait_rsp(tv);
      chk("bp_lat", tv - ta, 3);
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         chk("bp_valid", rsp_valid, 1);
         chk("bp_count", rsp_count, 8);
         chk("bp_data", rsp_data, 64'hF000_0000_0000_0000);
         chk("bp_ready1", req1_ready, 0);
      end
      @(posedge clock); #1 rsp_ready = 1;
      @(negedge clock);
      th = cyc;
      chk("bp_ready1_hs", req1_ready, 0);
      @(negedge clock);
      chk("bp_ready1_next", req1_ready, 1);
      ta = cyc;
      chk("bp_accept_gap", ta - th, 1);
      @(posedge clock); #1 req1_valid = 0;
      wait_rsp(tv);
      chk("bp2_id", rsp_id, 1);
      chk("bp2_count", rsp_count, 61);
      chk("bp2_data", rsp_data, 64'hA000_0000_0000_0000);

      // Reset during SCAN_LO
      accept(0, 64'h1, ta);
      @(posedge clock); #1 reset = 1;
      #1;
      chk("rst_mid_valid", rsp_valid, 0);
      chk("rst_mid_count", rsp_count, 0);
      chk("rst_mid_data", rsp_data, 0);
      chk("rst_mid_zero", rsp_zero, 0);
      chk("rst_mid_id", rsp_id, 0);
      @(posedge clock); #1 reset = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         chk("rst_no_rsp", rsp_valid, 0);
      end
      @(posedge clock); #1;
      req0_valid = 1; req0_data = 64'h2;
      req1_valid = 1; req1_data = 64'h4;
      @(negedge clock);
      chk("rst_ptr_r0", req0_ready, 1);
      chk("rst_ptr_r1", req1_ready, 0);
      @(posedge clock); #1 req0_valid = 0; req1_valid = 0;
      wait_rsp(tv);
      chk("rst_after_id", rsp_id, 0);
      chk("rst_after_count", rsp_count, 62);

      repeat (5) @(posedge clock);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lzc_norm_arb.md
# lzc_norm_arb

Shared 64-bit leading-zero normalizer that arbitrates one `lzc_32` instance between two requesters. The requesters are, for example, the add/sub and FMA result paths. The block accepts a 64-bit mantissa from the granted requester and scans it in two 32-bit halves through the single counter. It then left-shifts the mantissa so its MSB is set and returns the shift amount with the requester ID. It sits between the FPU result stages and the rounding stage.

## Interface
Parameters:
- none (data width fixed at 64, counter width fixed at 32)

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req0_valid`  in  1  requester 0 has an operand
- `req0_ready`  out  1  requester 0 operand accepted this cycle when valid
- `req0_data`  in  64  requester 0 mantissa
- `req1_valid`  in  1  requester 1 has an operand
- `req1_ready`  out  1  requester 1 operand accepted this cycle when valid
- `req1_data`  in  64  requester 1 mantissa
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer takes result
- `rsp_id`  out  1  requester that owns the result
- `rsp_count`  out  7  leading-zero count, 0..64
- `rsp_data`  out  64  normalized mantissa
- `rsp_zero`  out  1  operand was all zeros

## Operation
- The internal `lzc_32` returns `v` = any bit set, and `c` = bit index of the most-significant set bit. Leading zeros of a 32-bit half are therefore 31 − `c`.
- The FSM has five states: IDLE, SCAN_HI, SCAN_LO, SHIFT, DONE.
- **IDLE**
  - The grant is the requester that is valid. If both are valid, the grant goes to the round-robin pointer `ptr`.
  - `reqN_ready` = (state == IDLE) & (grant == N). It is combinational and is never asserted for both requesters.
  - On a valid&ready handshake, the block captures data and ID, sets `ptr` to the other requester, and moves to SCAN_HI.
  - `ptr` changes only on an accepted handshake.
- **SCAN_HI**: the counter is driven with data[63:32].
  - If `v`: count = 31 − `c`; go to SHIFT.
  - Otherwise: go to SCAN_LO.
- **SCAN_LO**: the counter is driven with data[31:0].
  - If `v`: count = 32 + (31 − `c`); `zero` = 0.
  - Otherwise: count = 64; `zero` = 1.
  - Go to SHIFT.
- **SHIFT**: data ← data << count. A count of 64 yields 0. Go to DONE.
- **DONE**: `rsp_valid` = 1. On `rsp_ready`, go to IDLE.
- No operand is accepted outside IDLE. Requesters hold valid and data until ready.
- The counter input is a registered-data mux selected by state. There is no other use of the counter.

## Timing
- Reset values:
  - state = IDLE, `ptr` = 0
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_count` = 0, `rsp_data` = 0, `rsp_zero` = 0
  - `req0_ready` and `req1_ready` follow IDLE (combinational)
- Latency, with the handshake in cycle T:
  - If upper half is nonzero: `rsp_valid` is high in cycle T+3.
  - If upper half is zero (including an all-zero operand): `rsp_valid` is high in cycle T+4.
- Backpressure: while `rsp_valid` & !`rsp_ready`, all `rsp_*` outputs hold stable.
- Throughput: the next acceptance occurs at the earliest one cycle after the `rsp` handshake, i.e. when back in IDLE. Minimum spacing is 4 cycles per operand.
- Simultaneous valid requests: only the `ptr` requester sees ready. The other keeps valid asserted and is granted on the next IDLE visit.
- Reset asserted mid-operation: the operation is abandoned and no response is issued. Outputs return to reset values asynchronously, and the FSM restarts in IDLE with `ptr` = 0.
- `rsp_count` and `rsp_zero` are registered in SCAN_HI/SCAN_LO. `rsp_data` is registered in SHIFT. All outputs are stable for the entire DONE interval.

## Test plan
- req0 = 0x0000_0001_0000_0000 accepted at T → at T+3, `rsp_valid` = 1, `rsp_id` = 0, `rsp_count` = 31, `rsp_data` = 0x8000_0000_0000_0000, `rsp_zero` = 0.
- req1 = 0x0000_0000_0000_0001 accepted at T → at T+4, `rsp_id` = 1, `rsp_count` = 63, `rsp_data` = 0x8000_0000_0000_0000.
- req0 = 0 → at T+4, `rsp_count` = 64, `rsp_zero` = 1, `rsp_data` = 0. req0 = 0x8000_0000_0000_0001 → `rsp_count` = 0, `rsp_data` unchanged.
- Both valid continuously from reset with `rsp_ready` = 1 → grants follow 0, 1, 0, 1. The ready signals are never both high, and the non-granted requester's data is never captured.
- `rsp_ready` held low 5 cycles during DONE (req0 = 0x00F0_0000_0000_0000) → `rsp_count` = 8 and `rsp_data` = 0xF000_0000_0000_0000 stay stable throughout. No new request is accepted until one cycle after `rsp_ready` rises.
- `reset` pulsed during SCAN_LO → `rsp_valid` never asserts for that operand, and all outputs are 0. After release, the first request is accepted from IDLE with `ptr` = 0.
